// File: rtl/rn_axis_pkt_checker_if.sv
// AXI-Stream bundle for the packet checker: data, keep, framing, size sideband and ready.
interface rn_axis_pkt_checker_if #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64,
    parameter int USER_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic [USER_W-1:0] tuser_size;
    logic              tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser_size, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser_size, output tready);
endinterface

// File: rtl/rn_axis_pkt_checker.sv
// AXI-Stream packet sink: checks framing, keep contiguity and size sideband per packet,
// keeps running statistics and can throttle tready with a periodic stall.
//   state  | meaning
//   IDLE   | waiting for the first beat of a packet
//   IN_PKT | at least one non-last beat accepted, packet in progress
module rn_axis_pkt_checker #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = 64,
    parameter int USER_SIZE_WIDTH = 16
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst,
    rn_axis_pkt_checker_if.slave       s_axis,
    input  logic                       throttle_en,
    input  logic [7:0]                 throttle_period,
    input  logic                       clr_stats,
    output logic                       pkt_done,
    output logic [USER_SIZE_WIDTH:0]   pkt_len,
    output logic [2:0]                 pkt_err,
    output logic [63:0]                last_beat_lo,
    output logic [31:0]                pkt_cnt,
    output logic [47:0]                byte_cnt,
    output logic [15:0]                err_cnt
);
    localparam int CNT_W = USER_SIZE_WIDTH + 1;
    localparam int POP_W = $clog2(AXIS_KEEP_WIDTH + 1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                     state, state_nxt;
    logic [USER_SIZE_WIDTH-1:0] exp_size;
    logic [CNT_W-1:0]           acc;
    logic                       acc_sat, keep_err_q, user_err_q;
    logic                       tready_q;
    logic [7:0]                 thr_cnt, thr_cnt_nxt, period_q;

    logic [POP_W-1:0]           pop;
    logic                       beat_ok, pkt_end;
    logic [CNT_W:0]             sum_wide;
    logic [CNT_W-1:0]           acc_nxt;
    logic                       sat_nxt, keep_bad, keep_nxt, user_nxt, size_bad;
    logic [USER_SIZE_WIDTH-1:0] cur_exp;
    logic [AXIS_KEEP_WIDTH-1:0] keep_inc;
    logic [2:0]                 err_vec;
    logic                       thr_active;

    assign s_axis.tready = tready_q;
    assign beat_ok       = s_axis.tvalid && tready_q;
    assign pkt_end       = beat_ok && s_axis.tlast;

    always_comb begin
        pop = '0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
            pop = pop + POP_W'(s_axis.tkeep[i]);
    end

    // Per-packet accumulation; IDLE means this beat starts a fresh packet.
    always_comb begin
        sum_wide = (state == IDLE) ? (CNT_W+1)'(pop) : ({1'b0, acc} + (CNT_W+1)'(pop));
        sat_nxt  = (state == IN_PKT) && acc_sat;
        acc_nxt  = sum_wide[CNT_W-1:0];
        if (sum_wide[CNT_W]) begin
            acc_nxt = '1;
            sat_nxt = 1'b1;
        end
        cur_exp  = (state == IDLE) ? s_axis.tuser_size : exp_size;
        keep_inc = s_axis.tkeep + AXIS_KEEP_WIDTH'(1);
        if (s_axis.tlast)
            keep_bad = (s_axis.tkeep == '0) || ((s_axis.tkeep & keep_inc) != '0);
        else
            keep_bad = (s_axis.tkeep != '1);
        keep_nxt = ((state == IN_PKT) && keep_err_q) || keep_bad;
        user_nxt = (state == IN_PKT) && (user_err_q || (s_axis.tuser_size != exp_size));
        size_bad = (acc_nxt != {1'b0, cur_exp}) || sat_nxt;
        err_vec  = {user_nxt, size_bad, keep_nxt};
    end

    always_comb begin
        state_nxt = state;
        if (beat_ok)
            state_nxt = s_axis.tlast ? IDLE : IN_PKT;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            exp_size   <= '0;
            acc        <= '0;
            acc_sat    <= 1'b0;
            keep_err_q <= 1'b0;
            user_err_q <= 1'b0;
        end else if (beat_ok) begin
            if (s_axis.tlast) begin
                exp_size   <= '0;
                acc        <= '0;
                acc_sat    <= 1'b0;
                keep_err_q <= 1'b0;
                user_err_q <= 1'b0;
            end else begin
                exp_size   <= cur_exp;
                acc        <= acc_nxt;
                acc_sat    <= sat_nxt;
                keep_err_q <= keep_nxt;
                user_err_q <= user_nxt;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_done     <= 1'b0;
            pkt_len      <= '0;
            pkt_err      <= '0;
            last_beat_lo <= '0;
        end else begin
            pkt_done <= pkt_end;
            if (pkt_end) begin
                pkt_len      <= acc_nxt;
                pkt_err      <= err_vec;
                last_beat_lo <= s_axis.tdata[63:0];
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_stats) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (beat_ok)
                byte_cnt <= byte_cnt + 48'(pop);
            if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 32'd1;
                if ((err_vec != '0) && (err_cnt != 16'hFFFF))
                    err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    // tready is registered, so it is derived from the counter value of the coming cycle.
    assign thr_active = throttle_en && (throttle_period > 8'd1);

    always_comb begin
        if ((throttle_period != period_q) || (throttle_period <= 8'd1))
            thr_cnt_nxt = '0;
        else if (thr_cnt >= throttle_period - 8'd1)
            thr_cnt_nxt = '0;
        else
            thr_cnt_nxt = thr_cnt + 8'd1;
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            thr_cnt  <= '0;
            period_q <= '0;
            tready_q <= 1'b0;
        end else begin
            thr_cnt  <= thr_cnt_nxt;
            period_q <= throttle_period;
            tready_q <= !(thr_active && (thr_cnt_nxt == throttle_period - 8'd1));
        end
    end
endmodule

// File: doc/rn_axis_pkt_checker.md
# rn_axis_pkt_checker

AXI-Stream packet sink and checker that sits directly downstream of the RecoNIC bench stimulus driver, in place of or alongside the DUT's streaming input. Per packet, it checks beat framing, keep contiguity and the consistency of the `tuser_size` sideband, and keeps running packet, byte and error statistics. It can also apply a periodic backpressure pattern on `tready` to exercise the upstream stall path.

## Interface
- `AXIS_DATA_WIDTH`, 512: stream data width in bits.
- `AXIS_KEEP_WIDTH`, 64: keep width; equals `AXIS_DATA_WIDTH`/8.
- `USER_SIZE_WIDTH`, 16: width of the packet-length sideband in bytes.
- `axis_clk`  in  1  sole clock.
- `axis_rst`  in  1  reset, asynchronous, active-high.
- `s_axis_tdata`  in  AXIS_DATA_WIDTH  beat data (ignored except for `last_beat_lo`).
- `s_axis_tkeep`  in  AXIS_KEEP_WIDTH  byte enables.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tlast`  in  1  last beat of the packet.
- `s_axis_tuser_size`  in  USER_SIZE_WIDTH  declared packet length in bytes.
- `s_axis_tready`  out  1  sink ready.
- `throttle_en`  in  1  enables periodic backpressure.
- `throttle_period`  in  8  backpressure period in cycles; 0 or 1 is treated as "no throttle".
- `clr_stats`  in  1  synchronous clear of the statistics counters.
- `pkt_done`  out  1  one-cycle pulse when a packet completes.
- `pkt_len`  out  USER_SIZE_WIDTH+1  counted bytes of the completed packet; valid with `pkt_done`.
- `pkt_err`  out  3  error flags of the completed packet: [0] keep, [1] size, [2] user-change. Valid with `pkt_done`.
- `last_beat_lo`  out  64  `tdata[63:0]` of the completed packet's last beat.
- `pkt_cnt`  out  32  packets completed; wraps.
- `byte_cnt`  out  48  total bytes accepted; wraps.
- `err_cnt`  out  16  packets with any error flag set; saturates at 0xFFFF.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready` on a rising edge of `axis_clk`.
- Two-state FSM:
  - IDLE: waiting for the first beat of a packet.
  - IN_PKT: mid-packet.
  - IDLE→IN_PKT: first beat accepted with `tlast`=0.
  - IN_PKT→IDLE: beat accepted with `tlast`=1.
  - A single-beat packet stays in IDLE.
- On the first beat of a packet (accepted in IDLE), latch `s_axis_tuser_size` as `exp_size`.
- Per-beat byte count is popcount(`tkeep`), 0..64. The per-packet accumulator is USER_SIZE_WIDTH+1 bits and saturates at its maximum.
- Keep error, sticky for the packet:
  - Non-last beat: `tkeep` not all ones.
  - Last beat: `tkeep` is zero, or `tkeep & (tkeep+1)` is nonzero (bytes not contiguous from bit 0).
- Size error: the final accumulated count differs from `exp_size`, or the accumulator saturated.
- User-change error: a beat accepted in IN_PKT has `tuser_size` different from `exp_size`. Sticky for the packet.
- On packet completion:
  - Register `pkt_len`, `pkt_err` and `last_beat_lo`; pulse `pkt_done`.
  - Increment `pkt_cnt`.
  - Increment `err_cnt` if `pkt_err` is nonzero.
  - Clear the per-packet state.
- `byte_cnt` adds popcount(`tkeep`) on every accepted beat.
- Throttle: a free-running 8-bit cycle counter counts 0..`throttle_period`-1.
  - `s_axis_tready` is 0 in the cycle where the counter equals `throttle_period`-1, and 1 otherwise.
  - When `throttle_en`=0 or `throttle_period`≤1: `s_axis_tready`=1 whenever reset is deasserted.
  - A change to `throttle_period` restarts the counter at 0.

## Timing
- Reset:
  - All outputs are 0, including `s_axis_tready`.
  - FSM is in IDLE; per-packet state is cleared.
- `s_axis_tready` is driven from a register; its value for cycle N is computed in cycle N-1.
- `pkt_done`, `pkt_len`, `pkt_err` and `last_beat_lo` update one cycle after the `tlast` handshake. `pkt_len`, `pkt_err` and `last_beat_lo` hold until the next completion.
- The counters update on the same edge as `pkt_done`. `byte_cnt` updates one cycle after each accepted beat.
- `clr_stats` zeroes `pkt_cnt`, `byte_cnt` and `err_cnt` on the next edge and overrides any simultaneous increment. It does not affect the FSM, per-packet state or `pkt_done`.
- `tvalid` low mid-packet (a gap) is legal; state is held.
- Reset asserted mid-packet: the partial packet is discarded with no `pkt_done`, and the next beat after release starts a new packet.
- Back-to-back packets with no idle cycle are supported at full rate.

## Test plan
- Reset release, `throttle_en`=0 → `s_axis_tready`=1 from the 2nd cycle after release; all counters are 0.
- 100-byte packet (beat 1: keep all ones; beat 2: keep 0xF_FFFF_FFFF), `tuser_size`=100 → `pkt_done` one cycle after `tlast`; `pkt_len`=100; `pkt_err`=0; `pkt_cnt`=1; `byte_cnt`=100.
- Same packet with `tuser_size`=99 → `pkt_err`=3'b010; `err_cnt`=1.
  - Variant: beat 1 keep 0xFFFF_FFFF_FFFF_FFFE → `pkt_err[0]`=1.
  - Variant: `tuser_size` changes to 101 on beat 2 → `pkt_err[2]`=1.
- `throttle_en`=1, `throttle_period`=4, 20 back-to-back 64-byte packets → `tready` low exactly every 4th cycle; `pkt_cnt`=20; `byte_cnt`=1280; no errors.
- `clr_stats` asserted in the same cycle as `pkt_done`'s counter update → counters read 0 next cycle; `pkt_done` still pulses.
- Reset asserted after beat 1 of a 3-beat packet, then a clean 64-byte packet is sent → exactly one `pkt_done`; `pkt_len`=64; `pkt_err`=0.
